multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Registered multicycle control unit for the MIPS-subset CPU: holds the current state, computes the next state from the opcode, and drives Moore control strobes to the datapath.
- Adds features the previous combinational next-state decoder lacks:
  - stall-by-handshake on memory accesses;
  - a memory timeout;
  - an illegal-opcode/timeout trap state with cause register;
  - an optional extended I-type opcode set;
  - a retired-instruction counter.

Parameters:
OPCODE_W, 6, opcode field width
EXT_EN, 1, 1 = ANDI(12)/ORI(13) legal; 0 = they trap
TMO_W, 4, width of memory-wait timeout counter; timeout after 2**TMO_W-1 waiting cycles
CNT_W, 32, width of instret counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPCODE_W  instruction[31:26], sampled in DECODE and later states
mem_ready  in  1  memory completes current mem_req this cycle
trap_ack  in  1  handler acknowledges trap
state  out  4  current state register
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
iord  out  1  1 = data address, 0 = PC address
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update if ALU zero
pc_source  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = const 4, 2 = signext imm, 3 = imm<<2 / upper imm
alu_op  out  3  0 add, 1 sub, 2 funct, 3 and, 4 or, 5 lui
reg_write  out  1  register file write
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
instr_done  out  1  one-cycle pulse on the final state of an instruction
trap  out  1  high while in TRAP
trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout; sticky until trap_ack
instret  out  CNT_W  count of completed instructions, wraps modulo 2**CNT_W

Behaviour:
- Reset (sync, dominates all inputs):
  - state = FETCH(0), trap_cause = 0, instret = 0, timeout counter = 0.
  - All strobes are Moore-decoded from state, so after reset only FETCH strobes are active (mem_req=1, iord=0, alu_src_b=1).
- States, transitions and strobes (all other strobes 0):
  - FETCH(0): mem_req, ir_write, pc_write, alu_src_b=1, pc_source=0. Goes to DECODE when mem_ready; otherwise holds. ir_write and pc_write are qualified by mem_ready.
  - DECODE(1): alu_src_b=3 (branch target precompute). Next state by opcode:
    - 35 or 43 -> MEM_ADDR(2)
    - 0 -> R_EXEC(6)
    - 4 -> BRANCH(8)
    - 2 -> JUMP(9)
    - 8 -> I_EXEC(12)
    - 15 -> LUI_EXEC(11)
    - 12 or 13 -> I_EXEC if EXT_EN, else TRAP
    - any other opcode -> TRAP(15) with cause 1
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=2. 35 -> MEM_READ(3); 43 -> MEM_WRITE(5).
  - MEM_READ(3): mem_req, iord. -> MEM_WB(4) when mem_ready.
  - MEM_WB(4): reg_write, mem_to_reg, reg_dst=0, instr_done. -> FETCH.
  - MEM_WRITE(5): mem_req, mem_we, iord. -> FETCH when mem_ready; instr_done pulses in that cycle only.
  - R_EXEC(6): alu_src_a=1, alu_op=2. -> R_WB(7).
  - R_WB(7): reg_write, reg_dst=1, instr_done. -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_op=1, pc_write_cond, pc_source=1, instr_done. -> FETCH.
  - JUMP(9): pc_write, pc_source=2, instr_done. -> FETCH.
  - I_WB(10): reg_write, reg_dst=0, instr_done. -> FETCH.
  - LUI_EXEC(11): alu_src_b=3, alu_op=5. -> I_WB.
  - I_EXEC(12): alu_src_a=1, alu_src_b=2, alu_op = 0 (op 8), 3 (op 12), 4 (op 13). -> I_WB.
  - TRAP(15): trap=1, no strobes. -> FETCH when trap_ack; trap_cause clears to 0 on that transition.
  - Codes 13 and 14 are unused: any such state -> TRAP with cause 1 on the next clock.
- Timeout:
  - The counter increments each cycle in FETCH/MEM_READ/MEM_WRITE while mem_ready=0, and clears on any state change.
  - On reaching 2**TMO_W-1 with mem_ready still 0 -> TRAP, cause 2.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- instret: increments by 1 on every cycle where instr_done=1; no increment for trapped instructions.
- Opcode is not registered here; the IR holds it stable from DECODE onward.
- trap_ack outside TRAP is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles -> state=0, mem_req=1, trap=0, trap_cause=0, instret=0.
- LW 35 with mem_ready=1 constantly -> state sequence 0,1,2,3,4,0; reg_write and mem_to_reg high only in state 4; instret=1.
- SW 43 with mem_ready low for 3 cycles in MEM_WRITE -> state holds at 5 with mem_we=1 for 4 cycles, then returns to 0; instr_done pulses once.
- Opcode 12 with EXT_EN=1 -> sequence 1,12,10,0 with alu_op=3. With EXT_EN=0 -> 1,15, trap_cause=1; trap_ack=1 -> state 0, cause cleared, instret unchanged.
- mem_ready held 0 in FETCH with TMO_W=4 -> TRAP entered after 15 waiting cycles, trap_cause=2. Repeat with mem_ready=1 on the 15th cycle -> DECODE, no trap.
- rst asserted while in MEM_READ -> next cycle state=0, instret=0; R-type 0 then BEQ 4 then J 2 back-to-back -> instret=3, pc_write_cond only in state 8, pc_source=2 in state 9.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit interface for the multicycle CPU. The controller uses the
// master modport; the datapath and memory side use the slave modport.
interface multicycle_ctrl_fsm_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
);
  // Inputs to the controller
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                trap_ack;

  // Outputs from the controller
  logic [3:0]          state;
  logic                mem_req;
  logic                mem_we;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_source;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_op;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                instr_done;
  logic                trap;
  logic [1:0]          trap_cause;
  logic [CNT_W-1:0]    instret;

  modport master (
    input  opcode, mem_ready, trap_ack,
    output state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, instr_done, trap, trap_cause, instret
  );

  modport slave (
    output opcode, mem_ready, trap_ack,
    input  state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, instr_done, trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the MIPS-subset CPU. Strobes are decoded from
// the next state and registered; only the handshake-qualified strobes
// (ir_write, pc_write, instr_done in memory-wait states) see mem_ready
// combinationally. Includes memory timeout, trap state with cause, and an
// instruction-retired counter.
module multicycle_ctrl_fsm #(
  parameter int OPCODE_W = 6,
  parameter bit EXT_EN   = 1'b1,
  parameter int TMO_W    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_WB      = 4'd10,
    S_LUI_EXEC  = 4'd11,
    S_I_EXEC    = 4'd12,
    S_TRAP      = 4'd15
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       trap;
    logic       wait_mem;   // state stalls on mem_ready; qualifies strobes
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);

  // Last counter value before the timeout fires: trap happens on the
  // (2**TMO_W-1)th consecutive waiting cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Moore strobe decode for a given state; op only selects the I-type ALU op
  function automatic ctrl_t decode(input state_e s, input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_b = 2'd1; c.wait_mem = 1'b1;
      end
      S_DECODE:   c.alu_src_b = 2'd3;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEM_READ: begin c.mem_req = 1'b1; c.iord = 1'b1; c.wait_mem = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      S_MEM_WRITE: begin
        c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1;
        c.instr_done = 1'b1; c.wait_mem = 1'b1;
      end
      S_R_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 3'd2; end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_write_cond = 1'b1;
        c.pc_source = 2'd1; c.instr_done = 1'b1;
      end
      S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'd2; c.instr_done = 1'b1; end
      S_I_WB:     begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_LUI_EXEC: begin c.alu_src_b = 2'd3; c.alu_op = 3'd5; end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        if (op == OP_ANDI)     c.alu_op = 3'd3;
        else if (op == OP_ORI) c.alu_op = 3'd4;
        else                   c.alu_op = 3'd0;
      end
      S_TRAP:     c.trap = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             tmo_hit;
  logic             strobe_ok;
  logic             instr_done;

  // Strobes of memory-wait states only fire in the cycle memory completes
  assign strobe_ok  = ~ctrl_q.wait_mem | bus.mem_ready;
  assign instr_done = ctrl_q.instr_done & strobe_ok;
  assign tmo_hit    = ctrl_q.wait_mem & ~bus.mem_ready & (tmo_q == TMO_LAST);

  // Next-state, trap cause, timeout counter and retired-count logic
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q + CNT_W'(instr_done);
    case (state_q)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          if (state_q == S_FETCH)         state_d = S_DECODE;
          else if (state_q == S_MEM_READ) state_d = S_MEM_WB;
          else                            state_d = S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_LUI:       state_d = S_LUI_EXEC;
          OP_ANDI, OP_ORI: begin
            if (EXT_EN) begin
              state_d = S_I_EXEC;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
        else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
      S_R_EXEC:                 state_d = S_R_WB;
      S_LUI_EXEC, S_I_EXEC:     state_d = S_I_WB;
      S_TRAP: begin
        if (bus.trap_ack) begin
          state_d = S_FETCH;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase

    if (state_d != state_q)                   tmo_d = '0;
    else if (ctrl_q.wait_mem && !bus.mem_ready) tmo_d = tmo_q + 1'b1;
    else                                      tmo_d = tmo_q;
  end

  // State register plus registered Moore strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode(S_FETCH, '0);
      tmo_q     <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decode(state_d, bus.opcode);
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.mem_req       = ctrl_q.mem_req;
  assign bus.mem_we        = ctrl_q.mem_we;
  assign bus.iord          = ctrl_q.iord;
  assign bus.ir_write      = ctrl_q.ir_write & strobe_ok;
  assign bus.pc_write      = ctrl_q.pc_write & strobe_ok;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.instr_done    = instr_done;
  assign bus.trap          = ctrl_q.trap;
  assign bus.trap_cause    = cause_q;
  assign bus.instret       = instret_q;

endmodule
